// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle core controller: opcodes, FSM states
// and the datapath mux-select encodings.
package mc_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    ST_IF    = 3'd0,
    ST_ID    = 3'd1,
    ST_EX    = 3'd2,
    ST_MEM   = 3'd3,
    ST_WB    = 3'd4,
    ST_PCINC = 3'd5,
    ST_HALT  = 3'd6,
    ST_ERROR = 3'd7
  } state_t;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_PC4    = 2'b10;

  // States that hold an outstanding memory access and are subject to the timeout.
  function automatic logic is_mem_wait_state(state_t s);
    return (s == ST_IF) || (s == ST_MEM);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready memory cycles and flags the cycle on which
// the tolerated wait budget runs out.
module mem_wait_timer #(
  parameter int MEM_WAIT_MAX = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic count_en,
  output logic expired
);

  localparam int W = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [W-1:0] LIMIT = W'(MEM_WAIT_MAX - 1);

  logic [W-1:0] count;

  // Any cycle that is not a stalled memory cycle restarts the count, which
  // also covers entry into IF/MEM and a completing access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + W'(1);
    end else begin
      count <= '0;
    end
  end

  assign expired = count_en && (count == LIMIT);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RISC-V control FSM: walks each instruction through IF/ID/EX/MEM/WB
// and drives the datapath enables and selects from state and opcode.
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic       bcond,
  input  logic       is_halt_req,
  input  logic       mem_ready,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       pc_to_reg,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       halted,
  output logic       mem_timeout,
  output logic [2:0] state
);

  state_t cur_state;
  state_t next_state;

  logic wait_expired;
  logic mem_stall;

  logic ir_write_dec;
  logic mem_write_dec;
  logic reg_write_dec;
  logic pc_write_dec;
  logic pc_write_cond_dec;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_state <= ST_IF;
    end else begin
      cur_state <= next_state;
    end
  end

  assign mem_stall = is_mem_wait_state(cur_state) && !mem_ready;

  mem_wait_timer #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX)
  ) u_mem_wait_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .count_en(mem_stall),
    .expired (wait_expired)
  );

  always_comb begin
    next_state        = cur_state;
    ir_write_dec      = 1'b0;
    mem_read          = 1'b0;
    mem_write_dec     = 1'b0;
    i_or_d            = 1'b0;
    reg_write_dec     = 1'b0;
    mem_to_reg        = 1'b0;
    pc_to_reg         = 1'b0;
    pc_write_dec      = 1'b0;
    pc_write_cond_dec = 1'b0;
    alu_src_a         = 1'b0;
    alu_src_b         = SRC_B_RS2;
    alu_op            = ALU_OP_ADD;
    pc_source         = PC_SRC_ALU;
    halted            = 1'b0;
    mem_timeout       = 1'b0;

    case (cur_state)
      ST_IF: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write_dec = 1'b1;
          next_state   = ST_ID;
        end else if (wait_expired) begin
          next_state = ST_ERROR;
        end
      end

      ST_ID: begin
        alu_src_b = SRC_B_IMM;
        if (opcode == OP_SYSTEM) begin
          next_state = is_halt_req ? ST_HALT : ST_PCINC;
        end else begin
          next_state = ST_EX;
        end
      end

      ST_EX: begin
        case (opcode)
          OP_R: begin
            alu_src_a  = 1'b1;
            alu_op     = ALU_OP_FUNCT;
            next_state = ST_WB;
          end
          OP_IMM: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRC_B_IMM;
            alu_op     = ALU_OP_FUNCT;
            next_state = ST_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRC_B_IMM;
            next_state = ST_MEM;
          end
          OP_BRANCH: begin
            alu_src_a         = 1'b1;
            alu_op            = ALU_OP_BRANCH;
            pc_write_cond_dec = 1'b1;
            pc_source         = PC_SRC_ALUOUT;
            next_state        = bcond ? ST_IF : ST_PCINC;
          end
          OP_JAL: begin
            reg_write_dec = 1'b1;
            pc_to_reg     = 1'b1;
            pc_write_dec  = 1'b1;
            pc_source     = PC_SRC_ALUOUT;
            next_state    = ST_IF;
          end
          OP_JALR: begin
            alu_src_a     = 1'b1;
            alu_src_b     = SRC_B_IMM;
            reg_write_dec = 1'b1;
            pc_to_reg     = 1'b1;
            pc_write_dec  = 1'b1;
            pc_source     = PC_SRC_ALU;
            next_state    = ST_IF;
          end
          // Unrecognised opcodes idle through EX and then just advance the PC.
          default: begin
            next_state = ST_PCINC;
          end
        endcase
      end

      ST_MEM: begin
        i_or_d        = 1'b1;
        mem_read      = (opcode != OP_STORE);
        mem_write_dec = (opcode == OP_STORE);
        if (mem_ready) begin
          if (opcode == OP_STORE) begin
            pc_write_dec = 1'b1;
            pc_source    = PC_SRC_PC4;
            next_state   = ST_IF;
          end else begin
            next_state = ST_WB;
          end
        end else if (wait_expired) begin
          next_state = ST_ERROR;
        end
      end

      ST_WB: begin
        reg_write_dec = 1'b1;
        mem_to_reg    = (opcode == OP_LOAD);
        pc_write_dec  = 1'b1;
        pc_source     = PC_SRC_PC4;
        next_state    = ST_IF;
      end

      ST_PCINC: begin
        pc_write_dec = 1'b1;
        pc_source    = PC_SRC_PC4;
        next_state   = ST_IF;
      end

      ST_HALT: begin
        halted = 1'b1;
      end

      ST_ERROR: begin
        mem_timeout = 1'b1;
      end

      default: begin
        next_state = ST_IF;
      end
    endcase
  end

  // Write enables are qualified by reset_n so none can pulse while reset is held.
  assign ir_write      = ir_write_dec      & reset_n;
  assign mem_write     = mem_write_dec     & reset_n;
  assign reg_write     = reg_write_dec     & reset_n;
  assign pc_write      = pc_write_dec      & reset_n;
  assign pc_write_cond = pc_write_cond_dec & reset_n;

  assign state = cur_state;

endmodule
